// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - state encoding, priority-mode constants and line-geometry helpers
// for the off-chip memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WB_WAIT = 2'd1,
      S_RD_WAIT = 2'd2,
      S_DONE    = 2'd3
   } arb_state_e;

   localparam int PRIO_RR    = 0;
   localparam int PRIO_FIXED = 1;

   function automatic int line_bits(input int line_bytes);
      return line_bytes * 8;
   endfunction

   function automatic int off_width(input int line_bytes);
      return (line_bytes > 1) ? $clog2(line_bytes) : 0;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [31:0] line_align(input logic [31:0] addr, input int line_bytes);
      return addr & ~((32'd1 << off_width(line_bytes)) - 32'd1);
   endfunction

endpackage

// File: rtl/mem_arb_rr_picker.sv
// rtl/mem_arb_rr_picker.sv - one-hot winner selection: round-robin from ptr_i+1,
// or fixed priority (lowest index) when mode_i is set.
module mem_arb_rr_picker import mem_arb_pkg::*; #(
   parameter  int NUM_CH = 2,
   localparam int IDX_W  = idx_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IDX_W-1:0]  ptr_i,
   input  logic              mode_i,
   output logic [NUM_CH-1:0] gnt_o
);

   logic [IDX_W-1:0] idx;
   logic             found;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (mode_i) idx = IDX_W'(i);
         else        idx = IDX_W'((int'(ptr_i) + i + 1) % NUM_CH);
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one off-chip line port between NUM_CH cache channels
// (writeback then fill per grant). Optional ready-wait timeout: MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter import mem_arb_pkg::*; #(
   parameter  int NUM_CH         = 2,
   parameter  int LINE_BYTES     = 16,
   parameter  int PRIO_MODE      = PRIO_RR,
   parameter  int TIMEOUT_CYCLES = 256,
   localparam int LINE_BITS      = line_bits(LINE_BYTES),
   localparam int IDX_W          = idx_width(NUM_CH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CH-1:0]           ch_req,
   input  logic [NUM_CH-1:0]           ch_wb,
   input  logic [NUM_CH-1:0]           ch_rd,
   input  logic [NUM_CH*32-1:0]        ch_wb_addr,
   input  logic [NUM_CH*32-1:0]        ch_fill_addr,
   input  logic [NUM_CH*LINE_BITS-1:0] ch_wb_data,
   output logic [NUM_CH-1:0]           ch_gnt,
   output logic [NUM_CH-1:0]           ch_done,
   output logic [NUM_CH-1:0]           ch_err,
   output logic [LINE_BITS-1:0]        fill_data,
   output logic [31:0]                 offchip_mem_addr,
   output logic                        offchip_mem_read_en,
   output logic                        offchip_mem_write_en,
   output logic [LINE_BITS-1:0]        offchip_mem_wdata,
   input  logic [LINE_BITS-1:0]        offchip_mem_data,
   input  logic                        offchip_mem_ready,
   output logic                        arb_busy
);

   arb_state_e           state_q, state_d;
   logic [NUM_CH-1:0]    gnt_q, gnt_d, done_q, done_d, win_oh;
   logic [IDX_W-1:0]     ptr_q, ptr_d, owner_q, owner_d, win_idx;
   logic                 rd_q, rd_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
   logic [31:0]          fill_addr_q, fill_addr_d, addr_q, addr_d;
   logic [LINE_BITS-1:0] wdata_q, wdata_d, fill_q, fill_d;

   logic [31:0]          wb_addr_a   [NUM_CH];
   logic [31:0]          fill_addr_a [NUM_CH];
   logic [LINE_BITS-1:0] wb_data_a   [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
      assign wb_addr_a[g]   = ch_wb_addr[g*32 +: 32];
      assign fill_addr_a[g] = ch_fill_addr[g*32 +: 32];
      assign wb_data_a[g]   = ch_wb_data[g*LINE_BITS +: LINE_BITS];
   end

   mem_arb_rr_picker #(.NUM_CH(NUM_CH)) u_picker (
      .req_i  (ch_req),
      .ptr_i  (ptr_q),
      .mode_i (PRIO_MODE == PRIO_FIXED),
      .gnt_o  (win_oh)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (win_oh[i]) win_idx = IDX_W'(i);
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   logic [31:0]       cnt_q, cnt_d;
   logic [NUM_CH-1:0] err_q, err_d;
   logic              timeout;

   assign timeout = (cnt_q == 32'(TIMEOUT_CYCLES - 1));

   // Counter restarts on every wait-state entry, including the WB_WAIT -> RD_WAIT hop.
   always_comb begin
      cnt_d = '0;
      err_d = '0;
      if ((state_q == S_WB_WAIT || state_q == S_RD_WAIT) && state_d == state_q)
         cnt_d = cnt_q + 32'd1;
      if ((state_q == S_WB_WAIT || state_q == S_RD_WAIT) && !offchip_mem_ready && timeout)
         err_d[owner_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign ch_err = err_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
   assign ch_err = '0;
`endif

   always_comb begin
      state_d     = state_q;
      gnt_d       = '0;
      done_d      = '0;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      rd_d        = rd_q;
      wr_en_d     = wr_en_q;
      rd_en_d     = rd_en_q;
      fill_addr_d = fill_addr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      fill_d      = fill_q;
      case (state_q)
         S_IDLE: begin
            if (|ch_req) begin
               owner_d     = win_idx;
               ptr_d       = win_idx;
               gnt_d       = win_oh;
               rd_d        = ch_rd[win_idx];
               fill_addr_d = line_align(fill_addr_a[win_idx], LINE_BYTES);
               wdata_d     = wb_data_a[win_idx];
               if (ch_wb[win_idx]) begin
                  state_d = S_WB_WAIT;
                  wr_en_d = 1'b1;
                  addr_d  = line_align(wb_addr_a[win_idx], LINE_BYTES);
               end else if (ch_rd[win_idx]) begin
                  state_d = S_RD_WAIT;
                  rd_en_d = 1'b1;
                  addr_d  = line_align(fill_addr_a[win_idx], LINE_BYTES);
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_WB_WAIT: begin
            if (offchip_mem_ready) begin
               wr_en_d = 1'b0;
               if (rd_q) begin
                  rd_en_d = 1'b1;
                  addr_d  = fill_addr_q;
                  state_d = S_RD_WAIT;
               end else begin
                  state_d = S_DONE;
               end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (timeout) begin
               wr_en_d = 1'b0;
               state_d = S_DONE;
            end
`endif
         end
         S_RD_WAIT: begin
            if (offchip_mem_ready) begin
               rd_en_d = 1'b0;
               fill_d  = offchip_mem_data;
               state_d = S_DONE;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (timeout) begin
               rd_en_d = 1'b0;
               state_d = S_DONE;
            end
`endif
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_DONE && state_q != S_DONE) done_d[owner_d] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         gnt_q       <= '0;
         done_q      <= '0;
         ptr_q       <= IDX_W'(NUM_CH - 1);
         owner_q     <= '0;
         rd_q        <= 1'b0;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         fill_addr_q <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         fill_q      <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         rd_q        <= rd_d;
         wr_en_q     <= wr_en_d;
         rd_en_q     <= rd_en_d;
         fill_addr_q <= fill_addr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         fill_q      <= fill_d;
      end
   end

   assign ch_gnt               = gnt_q;
   assign ch_done              = done_q;
   assign fill_data            = fill_q;
   assign offchip_mem_addr     = addr_q;
   assign offchip_mem_read_en  = rd_en_q;
   assign offchip_mem_write_en = wr_en_q;
   assign offchip_mem_wdata    = wdata_q;
   assign arb_busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench: vector table plus scoreboard queue,
// arbitration, reset-abort and (with MEM_ARB_TIMEOUT_EN) timeout sequences.
module tb_mem_port_arbiter;

   localparam int NCH   = 2;
   localparam int LBITS = 128;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    ch_req, ch_wb, ch_rd;
   logic [NCH*32-1:0] ch_wb_addr, ch_fill_addr;
   logic [NCH*LBITS-1:0] ch_wb_data;
   logic [NCH-1:0]    ch_gnt, ch_done, ch_err;
   logic [LBITS-1:0]  fill_data, wdata, rdata;
   logic [31:0]       addr;
   logic              rd_en, wr_en, ready, busy;
   logic [NCH-1:0]    fp_gnt, fp_done, fp_err;
   logic [LBITS-1:0]  fp_fill, fp_wdata;
   logic [31:0]       fp_addr;
   logic              fp_rd, fp_wr, fp_busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(.NUM_CH(NCH), .LINE_BYTES(16), .PRIO_MODE(0), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_wb(ch_wb), .ch_rd(ch_rd),
      .ch_wb_addr(ch_wb_addr), .ch_fill_addr(ch_fill_addr), .ch_wb_data(ch_wb_data),
      .ch_gnt(ch_gnt), .ch_done(ch_done), .ch_err(ch_err), .fill_data(fill_data),
      .offchip_mem_addr(addr), .offchip_mem_read_en(rd_en), .offchip_mem_write_en(wr_en),
      .offchip_mem_wdata(wdata), .offchip_mem_data(rdata), .offchip_mem_ready(ready),
      .arb_busy(busy));

   mem_port_arbiter #(.NUM_CH(NCH), .LINE_BYTES(16), .PRIO_MODE(1), .TIMEOUT_CYCLES(8)) dut_fp (
      .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_wb(ch_wb), .ch_rd(ch_rd),
      .ch_wb_addr(ch_wb_addr), .ch_fill_addr(ch_fill_addr), .ch_wb_data(ch_wb_data),
      .ch_gnt(fp_gnt), .ch_done(fp_done), .ch_err(fp_err), .fill_data(fp_fill),
      .offchip_mem_addr(fp_addr), .offchip_mem_read_en(fp_rd), .offchip_mem_write_en(fp_wr),
      .offchip_mem_wdata(fp_wdata), .offchip_mem_data(rdata), .offchip_mem_ready(ready),
      .arb_busy(fp_busy));

   typedef struct {
      int          ch;
      logic        wb, rd;
      logic [31:0] wb_addr, fill_addr;
      logic [7:0]  wbyte, rbyte;
      int          wdly, rdly;
      logic        rdy_idle;
      logic [31:0] exp_wb_addr, exp_fill_addr;
      int          exp_wr, exp_rd;
      logic [7:0]  exp_fill;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [NCH-1:0]   gnt;
      logic [31:0]      wb_addr, fill_addr;
      logic [LBITS-1:0] wdata, fill;
      int               wr_cyc, rd_cyc;
      logic             err;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[5];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(int ch, logic wb, logic rd, logic [31:0] wa, logic [31:0] fa,
                               logic [7:0] wby, logic [7:0] rby, int wd, int rdd, logic ri,
                               logic [31:0] ewa, logic [31:0] efa, int ewr, int erd,
                               logic [7:0] ef, logic ee);
      vec_t v;
      v.ch = ch; v.wb = wb; v.rd = rd; v.wb_addr = wa; v.fill_addr = fa;
      v.wbyte = wby; v.rbyte = rby; v.wdly = wd; v.rdly = rdd; v.rdy_idle = ri;
      v.exp_wb_addr = ewa; v.exp_fill_addr = efa; v.exp_wr = ewr; v.exp_rd = erd;
      v.exp_fill = ef; v.exp_err = ee;
      return v;
   endfunction

   task automatic chk(input string name, input logic [LBITS-1:0] act, input logic [LBITS-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input vec_t v, input string tag);
      exp_t           e;
      int             cyc = 0, wcnt = 0, rcnt = 0, gnt_pulses = 0, gnt_cyc = -1, done_cyc = -1;
      int             both_hi = 0, bad = 0;
      logic           seen_done = 1'b0, err_obs = 1'b0;
      logic [NCH-1:0] gnt_obs = '0, done_obs = '0;
      logic [LBITS-1:0] fill_obs = '0;
      @(negedge clk);
      ch_req = '0; ch_wb = '0; ch_rd = '0;
      ch_req[v.ch] = 1'b1; ch_wb[v.ch] = v.wb; ch_rd[v.ch] = v.rd;
      ch_wb_addr[v.ch*32 +: 32]         = v.wb_addr;
      ch_fill_addr[v.ch*32 +: 32]       = v.fill_addr;
      ch_wb_data[v.ch*LBITS +: LBITS]   = {16{v.wbyte}};
      rdata = {16{v.rbyte}};
      ready = v.rdy_idle;
      e.gnt = '0; e.gnt[v.ch] = 1'b1;
      e.wb_addr = v.exp_wb_addr; e.fill_addr = v.exp_fill_addr;
      e.wdata = {16{v.wbyte}}; e.fill = {16{v.exp_fill}};
      e.wr_cyc = v.exp_wr; e.rd_cyc = v.exp_rd; e.err = v.exp_err;
      sb_q.push_back(e);
      while (!seen_done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            ch_wb_addr[v.ch*32 +: 32]       = ~v.wb_addr;
            ch_fill_addr[v.ch*32 +: 32]     = ~v.fill_addr;
            ch_wb_data[v.ch*LBITS +: LBITS] = ~{16{v.wbyte}};
         end
         if (ch_gnt != '0) begin gnt_obs |= ch_gnt; gnt_pulses++; gnt_cyc = cyc; end
         if (wr_en && rd_en) both_hi++;
         if (wr_en) begin
            wcnt++;
            if (addr !== v.exp_wb_addr) bad++;
            if (wdata !== {16{v.wbyte}}) bad++;
         end
         if (rd_en) begin
            rcnt++;
            if (addr !== v.exp_fill_addr) bad++;
         end
         ready = (wr_en && wcnt == v.wdly + 1) || (rd_en && rcnt == v.rdly + 1) ||
                 (!wr_en && !rd_en && v.rdy_idle);
         if (ch_done != '0) begin
            seen_done = 1'b1; done_obs = ch_done; done_cyc = cyc;
            err_obs = ch_err[v.ch]; fill_obs = fill_data;
            ch_req = '0; ch_wb = '0; ch_rd = '0;
         end
      end
      ready = 1'b0;
      chk({tag, "_done_seen"}, seen_done, 1'b1);
      e = sb_q.pop_front();
      chk({tag, "_gnt"}, gnt_obs, e.gnt);
      chk({tag, "_gnt_pulses"}, gnt_pulses, 1);
      chk({tag, "_gnt_cyc"}, gnt_cyc, 1);
      chk({tag, "_done_ch"}, done_obs, e.gnt);
      chk({tag, "_wr_cycles"}, wcnt, e.wr_cyc);
      chk({tag, "_rd_cycles"}, rcnt, e.rd_cyc);
      chk({tag, "_done_cyc"}, done_cyc, 1 + e.wr_cyc + e.rd_cyc);
      chk({tag, "_both_strobes"}, both_hi, 0);
      chk({tag, "_addr_data_stable"}, bad, 0);
      chk({tag, "_fill_data"}, fill_obs, e.fill);
      chk({tag, "_err"}, err_obs, e.err);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, ch_done, '0);
      chk({tag, "_idle_after"}, busy, 1'b0);
   endtask

   initial begin
      int             rr_n, fp_n, cyc;
      logic [NCH-1:0] rr_g [4];
      logic [NCH-1:0] fp_g [4];
      logic [NCH-1:0] exp_rr [4];
      logic           done_during_rst;

      vecs[0] = mk(0, 0, 1, 32'h0, 32'h1000_0008, 8'h00, 8'hA5, 0, 3, 0,
                   32'h0, 32'h1000_0000, 0, 4, 8'hA5, 0);
      vecs[1] = mk(1, 1, 1, 32'h2000_0010, 32'h3000_0020, 8'h3C, 8'h5A, 2, 1, 0,
                   32'h2000_0010, 32'h3000_0020, 3, 2, 8'h5A, 0);
      vecs[2] = mk(0, 1, 0, 32'h4000_001F, 32'h0, 8'hC3, 8'hEE, 0, 0, 0,
                   32'h4000_0010, 32'h0, 1, 0, 8'h5A, 0);
      vecs[3] = mk(1, 0, 0, 32'h0, 32'h0, 8'h00, 8'h11, 0, 0, 1,
                   32'h0, 32'h0, 0, 0, 8'h5A, 0);
      vecs[4] = mk(1, 0, 1, 32'h0, 32'h0000_000F, 8'h00, 8'h96, 0, 5, 0,
                   32'h0, 32'h0000_0000, 0, 6, 8'h96, 0);

      rst_n = 1'b0; ch_req = '0; ch_wb = '0; ch_rd = '0;
      ch_wb_addr = '0; ch_fill_addr = '0; ch_wb_data = '0; rdata = '0; ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_gnt", ch_gnt, '0);
      chk("rst_done", ch_done, '0);
      chk("rst_err", ch_err, '0);
      chk("rst_strobes", {rd_en, wr_en}, 2'b00);
      chk("rst_addr", addr, 32'h0);
      chk("rst_fill", fill_data, '0);
      chk("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      // both channels request continuously
      exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
      for (int i = 0; i < 4; i++) begin rr_g[i] = '0; fp_g[i] = '0; end
      rr_n = 0; fp_n = 0; cyc = 0;
      ch_req = 2'b11; ch_wb = '0; ch_rd = '0;
      while ((rr_n < 4 || fp_n < 4) && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (ch_gnt != '0 && rr_n < 4) begin rr_g[rr_n] = ch_gnt; rr_n++; end
         if (fp_gnt != '0 && fp_n < 4) begin fp_g[fp_n] = fp_gnt; fp_n++; end
      end
      ch_req = '0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr_grant%0d", i), rr_g[i], exp_rr[i]);
         chk($sformatf("fixed_grant%0d", i), fp_g[i], 2'b01);
      end
      repeat (3) @(negedge clk);

      // reset in the middle of a fill wait
      ch_req = 2'b01; ch_rd = 2'b01; ch_wb = '0; ch_fill_addr[31:0] = 32'h5000_0000;
      repeat (3) @(negedge clk);
      chk("pre_rst_rd_en", rd_en, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_rd_en", rd_en, 1'b0);
      chk("rst_mid_busy", busy, 1'b0);
      ch_req = '0; ch_rd = '0;
      done_during_rst = 1'b0;
      repeat (2) begin @(negedge clk); if (ch_done != '0) done_during_rst = 1'b1; end
      rst_n = 1'b1;
      repeat (2) begin @(negedge clk); if (ch_done != '0) done_during_rst = 1'b1; end
      chk("rst_mid_no_done", done_during_rst, 1'b0);
      run_txn(mk(1, 0, 1, 32'h0, 32'h6000_0044, 8'h00, 8'h77, 0, 1, 0,
                 32'h0, 32'h6000_0040, 0, 2, 8'h77, 0), "post_rst");

`ifdef MEM_ARB_TIMEOUT_EN
      run_txn(mk(0, 0, 1, 32'h0, 32'h7000_0000, 8'h00, 8'hFF, 0, 1000, 0,
                 32'h0, 32'h7000_0000, 0, 8, 8'h77, 1), "timeout");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
